// File: rtl/decode_read_execute_if.sv
// Fetch-window / write-back / debug bundle between the decode-read-execute
// pipeline (slave) and whatever feeds and observes it (master).
interface decode_read_execute_if;
  logic [119:0] decode_bytes;
  logic         can_decode;
  logic [3:0]   bytes_decoded;
  logic         wb_valid;
  logic [3:0]   wb_reg;
  logic [63:0]  wb_value;
  logic [63:0]  rflags;
  logic [3:0]   dbg_sel;
  logic [63:0]  dbg_val;

  modport master (
    output decode_bytes, can_decode, dbg_sel,
    input  bytes_decoded, wb_valid, wb_reg, wb_value, rflags, dbg_val
  );

  modport slave (
    input  decode_bytes, can_decode, dbg_sel,
    output bytes_decoded, wb_valid, wb_reg, wb_value, rflags, dbg_val
  );
endinterface

// File: rtl/decode_read_execute.sv
// Three-stage x86-64 subset pipeline: Decode -> Read -> Execute.
// Decode is combinational on the fetch window, Read pulls operands from the
// regfile with EX->RD forwarding (never stalls), Execute computes the result
// and flags which are committed at the edge that ends the EX cycle.
module decode_read_execute (
  input logic                  clk,
  input logic                  reset,
  decode_read_execute_if.slave bus
);
  typedef enum logic [2:0] {
    OP_ADD, OP_OR, OP_AND, OP_SUB, OP_XOR, OP_CMP, OP_MOV, OP_NOP
  } alu_op_e;

  typedef struct packed {
    alu_op_e     aop;
    logic        w;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic        use_imm;
    logic [63:0] imm;
  } id_rd_t;

  typedef struct packed {
    alu_op_e     aop;
    logic        w;
    logic [3:0]  dst;
    logic [63:0] a;
    logic [63:0] b;
  } rd_ex_t;

  logic [63:0] regs [16];
  logic [63:0] flags_q;
  logic [2:1]  vld_pipe;
  id_rd_t      dec, id_rd;
  rd_ex_t      rd_nxt, rd_ex;

  logic        rex, rw, rr, rb, dec_ok, dec_vld;
  logic [3:0]  off, dec_len, bd;
  logic [71:0] win;
  logic [7:0]  opc, modrm;

  // window bytes past the longest instruction and REX.X carry no meaning here
  logic        unused_bits;
  assign unused_bits = ^{bus.decode_bytes[119:80], bus.decode_bytes[1]};

  // Decode: optional REX, then opcode; window is shifted so opcode is byte 0
  always_comb begin
    rex     = bus.decode_bytes[7:4] == 4'h4;
    rw      = rex & bus.decode_bytes[3];
    rr      = rex & bus.decode_bytes[2];
    rb      = rex & bus.decode_bytes[0];
    off     = {3'b000, rex};
    win     = rex ? bus.decode_bytes[79:8] : bus.decode_bytes[71:0];
    opc     = win[7:0];
    modrm   = win[15:8];
    dec     = '0;
    dec.aop = OP_NOP;
    dec.w   = rw;
    dec.dst = {rb, modrm[2:0]};
    dec.src = {rr, modrm[5:3]};
    dec_ok  = 1'b0;
    dec_len = 4'd0;
    case (opc)
      8'h01, 8'h09, 8'h21, 8'h29, 8'h31, 8'h39, 8'h89: begin
        dec_ok  = modrm[7:6] == 2'b11;
        dec_len = off + 4'd2;
        case (opc)
          8'h01:   dec.aop = OP_ADD;
          8'h09:   dec.aop = OP_OR;
          8'h21:   dec.aop = OP_AND;
          8'h29:   dec.aop = OP_SUB;
          8'h31:   dec.aop = OP_XOR;
          8'h39:   dec.aop = OP_CMP;
          default: dec.aop = OP_MOV;
        endcase
      end
      8'h81, 8'h83: begin
        dec.use_imm = 1'b1;
        // /2 (ADC) and /3 (SBB) are not supported
        dec_ok = (modrm[7:6] == 2'b11) && (modrm[5:4] != 2'b01);
        case (modrm[5:3])
          3'd0:    dec.aop = OP_ADD;
          3'd1:    dec.aop = OP_OR;
          3'd4:    dec.aop = OP_AND;
          3'd5:    dec.aop = OP_SUB;
          3'd6:    dec.aop = OP_XOR;
          3'd7:    dec.aop = OP_CMP;
          default: dec.aop = OP_NOP;
        endcase
        if (opc[1]) begin
          dec.imm = {{56{win[23]}}, win[23:16]};
          dec_len = off + 4'd3;
        end else begin
          dec.imm = {{32{win[47]}}, win[47:16]};
          dec_len = off + 4'd6;
        end
      end
      8'h90: begin
        dec_ok  = 1'b1;
        dec_len = off + 4'd1;
      end
      default: begin
        if (opc[7:3] == 5'b10111) begin
          dec_ok      = 1'b1;
          dec.aop     = OP_MOV;
          dec.use_imm = 1'b1;
          dec.dst     = {rb, opc[2:0]};
          if (rw) begin
            dec.imm = win[71:8];
            dec_len = off + 4'd9;
          end else begin
            dec.imm = {32'h0, win[39:8]};
            dec_len = off + 4'd5;
          end
        end
      end
    endcase
    dec_vld = reset & bus.can_decode & dec_ok;
    // illegal / memory-form instructions are skipped one byte at a time
    if (!reset || !bus.can_decode) bd = 4'd0;
    else if (dec_ok)               bd = dec_len;
    else                           bd = 4'd1;
  end

  logic [63:0] ea, eb, res;
  logic [64:0] add65, sub65;
  logic [32:0] add33, sub33;
  logic        sa, sb, sr, cf, of, wr_en, fl_en;
  logic [63:0] nflags;

  // Execute: operate at 32 or 64 bits, 32-bit results zero-extended
  always_comb begin
    ea    = rd_ex.w ? rd_ex.a : {32'h0, rd_ex.a[31:0]};
    eb    = rd_ex.w ? rd_ex.b : {32'h0, rd_ex.b[31:0]};
    add65 = {1'b0, ea} + {1'b0, eb};
    sub65 = {1'b0, ea} - {1'b0, eb};
    add33 = {1'b0, ea[31:0]} + {1'b0, eb[31:0]};
    sub33 = {1'b0, ea[31:0]} - {1'b0, eb[31:0]};
    sa    = rd_ex.w ? ea[63] : ea[31];
    sb    = rd_ex.w ? eb[63] : eb[31];
    res   = '0;
    cf    = 1'b0;
    case (rd_ex.aop)
      OP_ADD: begin
        res = rd_ex.w ? add65[63:0] : {32'h0, add33[31:0]};
        cf  = rd_ex.w ? add65[64] : add33[32];
      end
      OP_SUB, OP_CMP: begin
        res = rd_ex.w ? sub65[63:0] : {32'h0, sub33[31:0]};
        cf  = rd_ex.w ? sub65[64] : sub33[32];
      end
      OP_OR:   res = ea | eb;
      OP_AND:  res = ea & eb;
      OP_XOR:  res = ea ^ eb;
      OP_MOV:  res = eb;
      default: res = '0;
    endcase
    sr = rd_ex.w ? res[63] : res[31];
    case (rd_ex.aop)
      OP_ADD:         of = (sa == sb) && (sr != sa);
      OP_SUB, OP_CMP: of = (sa != sb) && (sr != sa);
      default:        of = 1'b0;
    endcase
    nflags     = flags_q;
    nflags[0]  = cf;
    nflags[6]  = res == 64'h0;
    nflags[7]  = sr;
    nflags[11] = of;
    wr_en = vld_pipe[2] && (rd_ex.aop inside {OP_ADD, OP_OR, OP_AND, OP_SUB, OP_XOR, OP_MOV});
    fl_en = vld_pipe[2] && (rd_ex.aop inside {OP_ADD, OP_OR, OP_AND, OP_SUB, OP_XOR, OP_CMP});
  end

  // Read: operand fetch, bypassing the value EX is about to commit
  always_comb begin
    rd_nxt     = '0;
    rd_nxt.aop = id_rd.aop;
    rd_nxt.w   = id_rd.w;
    rd_nxt.dst = id_rd.dst;
    rd_nxt.a   = (wr_en && rd_ex.dst == id_rd.dst) ? res : regs[id_rd.dst];
    if (id_rd.use_imm)                   rd_nxt.b = id_rd.imm;
    else if (wr_en && rd_ex.dst == id_rd.src) rd_nxt.b = res;
    else                                 rd_nxt.b = regs[id_rd.src];
  end

  // Pipeline latches; a reset empties both stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      id_rd    <= '0;
      rd_ex    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], dec_vld};
      id_rd    <= dec;
      rd_ex    <= rd_nxt;
    end
  end

  // Architectural state commit at the end of the EX cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      flags_q <= 64'h202;
    end else begin
      if (wr_en) regs[rd_ex.dst] <= res;
      if (fl_en) flags_q <= nflags;
    end
  end

  assign bus.bytes_decoded = bd;
  assign bus.wb_valid      = wr_en;
  assign bus.wb_reg        = wr_en ? rd_ex.dst : 4'd0;
  assign bus.wb_value      = wr_en ? res : 64'h0;
  assign bus.rflags        = flags_q;
  assign bus.dbg_val       = regs[bus.dbg_sel];
endmodule

// File: tb/tb_decode_read_execute.sv
// Randomized bench for decode_read_execute. The reference model executes
// each instruction as plain sequential x86 at decode time and delays the
// architectural effect by the fixed pipeline latency.
module tb_decode_read_execute;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_read_execute_if bus ();
  decode_read_execute dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          wv;
    logic [3:0]  rg;
    logic [63:0] val;
    logic [63:0] fl;
  } rec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0]  wb [15];
  logic [63:0] spec_r [16];
  logic [63:0] arch_r [16];
  logic [63:0] spec_fl, arch_fl;
  rec_t        q [$];
  logic [3:0]  last_bd;
  logic [7:0]  alu_ops [7] = '{8'h01, 8'h09, 8'h21, 8'h29, 8'h31, 8'h39, 8'h89};
  int          grp [6] = '{0, 1, 4, 5, 6, 7};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rec_t b;
    for (int i = 0; i < 16; i++) begin spec_r[i] = '0; arch_r[i] = '0; end
    spec_fl = 64'h202;
    arch_fl = 64'h202;
    b.wv = 0; b.rg = '0; b.val = '0; b.fl = 64'h202;
    q = {};
    q.push_back(b);
    q.push_back(b);
  endtask

  // Sequential ISA semantics of the window in wb[]
  task automatic model(input bit cd, output int len, output rec_t rc);
    int p, n, dst, src, sbit;
    bit w, rr, rb, mov, legal, cf, of;
    logic [7:0]  opc, md;
    logic [63:0] a, bv, r, mask;
    rc.wv = 0; rc.rg = '0; rc.val = '0;
    len = 0;
    if (cd) begin
      p = 0; w = 0; rr = 0; rb = 0;
      if (wb[0] inside {[8'h40:8'h4F]}) begin
        p = 1; w = wb[0][3]; rr = wb[0][2]; rb = wb[0][0];
      end
      opc = wb[p]; md = wb[p+1];
      n = -1; mov = 0; legal = 0; dst = 0; bv = '0;
      if ((opc inside {8'h01, 8'h09, 8'h21, 8'h29, 8'h31, 8'h39, 8'h89}) && md[7:6] == 2'b11) begin
        legal = 1; len = p + 2;
        dst = int'(md[2:0]) + (rb ? 8 : 0);
        src = int'(md[5:3]) + (rr ? 8 : 0);
        bv = spec_r[src];
        if (opc == 8'h89) mov = 1; else n = int'(opc >> 3);
      end else if ((opc == 8'h81 || opc == 8'h83) && md[7:6] == 2'b11 &&
                   md[5:3] != 3'd2 && md[5:3] != 3'd3) begin
        legal = 1;
        n = int'(md[5:3]);
        dst = int'(md[2:0]) + (rb ? 8 : 0);
        if (opc == 8'h83) begin
          bv = longint'($signed(wb[p+2])); len = p + 3;
        end else begin
          bv = longint'($signed({wb[p+5], wb[p+4], wb[p+3], wb[p+2]})); len = p + 6;
        end
      end else if (opc inside {[8'hB8:8'hBF]}) begin
        legal = 1; mov = 1;
        dst = int'(opc[2:0]) + (rb ? 8 : 0);
        if (w) begin
          bv = '0;
          for (int k = 7; k >= 0; k--) bv = (bv << 8) | 64'(wb[p+1+k]);
          len = p + 9;
        end else begin
          bv = {32'h0, wb[p+4], wb[p+3], wb[p+2], wb[p+1]};
          len = p + 5;
        end
      end else if (opc == 8'h90) begin
        legal = 1; len = p + 1;
      end
      if (!legal) len = 1;
      else if (mov || n >= 0) begin
        mask = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sbit = w ? 63 : 31;
        a  = spec_r[dst] & mask;
        bv = bv & mask;
        cf = 0; of = 0;
        case (n)
          0: begin r = (a + bv) & mask; cf = r < a;
                   of = (a[sbit] == bv[sbit]) && (r[sbit] != a[sbit]); end
          5, 7: begin r = (a - bv) & mask; cf = a < bv;
                   of = (a[sbit] != bv[sbit]) && (r[sbit] != a[sbit]); end
          1: r = a | bv;
          4: r = a & bv;
          6: r = a ^ bv;
          default: r = bv;
        endcase
        if (n >= 0) begin
          spec_fl[0] = cf; spec_fl[6] = (r == 0); spec_fl[7] = r[sbit]; spec_fl[11] = of;
        end
        if (n != 7) begin
          spec_r[dst] = r;
          rc.wv = 1; rc.rg = 4'(dst); rc.val = r;
        end
      end
    end
    rc.fl = spec_fl;
  endtask

  // One cycle: drive at the falling edge, check just after, retire the oldest record
  task automatic step(input bit cd);
    int   len;
    rec_t rc, ex;
    logic [119:0] w;
    for (int i = 0; i < 15; i++) w[8*i +: 8] = wb[i];
    bus.decode_bytes = w;
    bus.can_decode   = cd;
    bus.dbg_sel      = 4'($urandom_range(0, 15));
    model(cd, len, rc);
    q.push_back(rc);
    #1;
    last_bd = bus.bytes_decoded;
    chk("bytes_decoded", 64'(bus.bytes_decoded), 64'(len));
    ex = q.pop_front();
    chk("wb_valid", 64'(bus.wb_valid), 64'(ex.wv));
    if (ex.wv) begin
      chk("wb_reg", 64'(bus.wb_reg), 64'(ex.rg));
      chk("wb_value", bus.wb_value, ex.val);
    end
    chk("rflags", bus.rflags, arch_fl);
    chk("dbg_val", bus.dbg_val, arch_r[bus.dbg_sel]);
    if (ex.wv) arch_r[ex.rg] = ex.val;
    arch_fl = ex.fl;
    @(negedge clk);
  endtask

  task automatic load(input logic [79:0] seq, input int n);
    for (int i = 0; i < 15; i++) wb[i] = 8'h00;
    for (int i = 0; i < n; i++) wb[i] = seq[8*(n-1-i) +: 8];
  endtask

  task automatic nop();
    load(80'h90, 1);
    step(1);
  endtask

  task automatic peek(input int r, input logic [63:0] e, input string tag);
    bus.dbg_sel = 4'(r);
    #1;
    chk(tag, bus.dbg_val, e);
  endtask

  // Assert reset at a falling edge, verify the cleared state, release one cycle later
  task automatic do_reset();
    reset = 1'b0;
    bus.can_decode = 1'b1;
    bus.decode_bytes = {$urandom, $urandom, $urandom, 24'h0, 32'h90909090};
    #1;
    chk("rst_bytes_decoded", 64'(bus.bytes_decoded), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_reg", 64'(bus.wb_reg), 64'd0);
    chk("rst_wb_value", bus.wb_value, 64'd0);
    chk("rst_rflags", bus.rflags, 64'h202);
    for (int r = 0; r < 16; r++) peek(r, 64'd0, "rst_reg");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic int pick3();
    return $urandom_range(0, 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
  endfunction

  task automatic gen();
    int p, k;
    for (int i = 0; i < 15; i++) wb[i] = 8'($urandom);
    p = 0;
    k = $urandom_range(0, 9);
    if (k != 8 && $urandom_range(0, 1) == 1) begin
      wb[0] = 8'(8'h40 | $urandom_range(0, 15));
      p = 1;
    end
    case (k)
      0, 1, 2, 3: begin
        wb[p]   = alu_ops[$urandom_range(0, 6)];
        wb[p+1] = 8'(8'hC0 | (pick3() << 3) | pick3());
      end
      4, 5: begin
        wb[p]   = (k == 4) ? 8'h81 : 8'h83;
        wb[p+1] = 8'(8'hC0 | (grp[$urandom_range(0, 5)] << 3) | pick3());
      end
      6, 7: begin
        wb[p] = 8'(8'hB8 | pick3());
        if ($urandom_range(0, 1) == 1) begin
          wb[p+1] = 8'($urandom_range(0, 3));
          for (int i = 2; i < 9; i++) wb[p+i] = 8'h00;
        end
      end
      8: wb[0] = 8'h90;
      default: begin
        case ($urandom_range(0, 3))
          0: wb[p] = 8'h0F;
          1: wb[p] = 8'h66;
          2: begin wb[p] = 8'h81; wb[p+1] = 8'(8'hD0 | ($urandom_range(0, 1) << 3) | pick3()); end
          default: begin wb[p] = 8'h01; wb[p+1] = 8'($urandom_range(0, 191)); end
        endcase
      end
    endcase
  endtask

  initial begin
    reset = 1'b0;
    bus.decode_bytes = '0;
    bus.can_decode = 1'b0;
    bus.dbg_sel = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 64-bit immediate move
    load(80'h48B8EFBEADDE78563412, 10); step(1);
    chk("mov64_len", 64'(last_bd), 64'd10);
    nop(); nop();
    peek(0, 64'h12345678DEADBEEF, "mov64_rax");

    // back-to-back dependency through forwarding
    load(80'hB800000000, 5); step(1);
    load(80'hB905000000, 5); step(1);
    load(80'h4801C8, 3);     step(1);
    nop(); nop();
    peek(0, 64'd5, "add_fwd_rax");
    chk("add_zf", 64'(bus.rflags[6]), 64'd0);

    // CMP sets flags, writes nothing
    load(80'h4883F805, 4); step(1);
    nop();
    chk("cmp_no_wb", 64'(bus.wb_valid), 64'd0);
    nop();
    peek(0, 64'd5, "cmp_rax");
    chk("cmp_zf", 64'(bus.rflags[6]), 64'd1);
    chk("cmp_cf", 64'(bus.rflags[0]), 64'd0);

    // 0 - 1 at 64 bits
    load(80'hB800000000, 5); step(1);
    load(80'h4883E801, 4);   step(1);
    nop(); nop();
    peek(0, 64'hFFFF_FFFF_FFFF_FFFF, "sub_rax");
    chk("sub_cf", 64'(bus.rflags[0]), 64'd1);
    chk("sub_sf", 64'(bus.rflags[7]), 64'd1);

    // no window, then an illegal byte
    load(80'h90, 1); step(0);
    chk("nodec_len", 64'(last_bd), 64'd0);
    load(80'h0F, 1); step(1);
    chk("illegal_len", 64'(last_bd), 64'd1);
    nop(); nop(); nop();
    peek(0, 64'hFFFF_FFFF_FFFF_FFFF, "illegal_rax");
    chk("illegal_rflags", bus.rflags, 64'h283);

    // reset with three instructions in flight
    load(80'hB807000000, 5); step(1);
    load(80'hB908000000, 5); step(1);
    load(80'h4801C8, 3);     step(1);
    do_reset();
    nop(); nop(); nop();

    for (int it = 0; it < 1500; it++) begin
      gen();
      step($urandom_range(0, 9) != 0);
      if (it % 400 == 399) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
